apb_reg_slave: RTL and testbench
================================

# apb_reg_slave

APB3 slave exposing a bank of general-purpose read/write registers. It sits behind the system's AXI4-Lite-to-APB bridge as a memory-mapped peripheral. It decodes only the low offset bits of the APB address, so it responds at any base address the interconnect assigns (e.g. 0x44A0_0000). It completes every transfer with zero wait states and flags illegal accesses through PSLVERR.

## Interface
- ADDR_WIDTH, default 32: width of i_paddr.
- DATA_WIDTH, default 32: width of i_pwdata, o_prdata and each register.
- NUM_REGS, default 16: number of registers, at word offsets 0x00 .. (NUM_REGS-1)*4. Legal range 1..1024.

- i_clk  in  1  single clock; all logic is on the rising edge.
- i_reset  in  1  one clock; reset is synchronous and active-high.
- i_psel  in  1  APB select.
- i_penable  in  1  APB enable (access phase).
- i_pwrite  in  1  1 = write, 0 = read.
- i_paddr  in  ADDR_WIDTH  byte address. Only bits [11:0] are decoded; higher bits are ignored.
- i_pwdata  in  DATA_WIDTH  write data.
- o_pready  out  1  transfer complete; registered.
- o_prdata  out  DATA_WIDTH  read data; registered.
- o_pslverr  out  1  error response; registered.

## Operation
- Register bank: NUM_REGS × DATA_WIDTH flops, all read/write, no side effects.
- Offset = i_paddr[11:0].
  - Register index = offset[11:2].
  - A transfer is legal when offset[1:0] == 0 and the index < NUM_REGS.
  - All other transfers are errors.
- Setup phase (i_psel=1, i_penable=0):
  - The slave latches the legality result.
  - For a legal read, it latches the selected register into o_prdata.
- Legal write:
  - The register is updated with i_pwdata at the edge that ends the access phase (i_psel & i_penable & o_pready & i_pwrite).
  - Full-word writes only; there is no byte strobe.
- Legal read: o_prdata holds the register value for the access cycle; o_pslverr=0.
- Error transfer:
  - o_pslverr=1 and o_prdata=0 during the access cycle.
  - A write changes no register.
- Outside an access cycle: o_prdata=0, o_pslverr=0, o_pready=0.
- Reset:
  - All registers and all outputs go to 0 at the next rising edge while i_reset=1.
  - A transfer in progress is aborted: no register update, o_pready stays 0.

## Timing
- Transfer of 2 cycles, zero wait states:
  - Cycle S (setup): at the S-edge, o_pready←1 and o_prdata/o_pslverr are loaded.
  - Cycle A (access): o_pready=1 with valid data and error flag. The write commits at the A-edge, where o_pready←0 and o_prdata←0 / o_pslverr←0.
- Back-to-back: a new setup phase may directly follow an access cycle. A read immediately after a write to the same index returns the new value, because the write commits at the A-edge before the next setup.
- o_pready rises only after a setup phase is seen. An access phase without a preceding setup (protocol violation) gets o_pready=0, and the slave does not hang once i_psel deasserts.
- i_penable without i_psel is ignored.
- Read latency: data is valid in the first access cycle, one edge after setup.

## Test plan
- Reset: hold i_reset=1 for 3 cycles with random APB inputs -> o_pready=0, o_prdata=0, o_pslverr=0; reading any register afterwards returns 0.
- Write then read, offset 0: write 0x0000_0123 to paddr 0x44A0_0000, then read 0x44A0_0000 -> o_prdata=0x0000_0123, o_pslverr=0, o_pready high exactly one cycle per transfer.
- Address aliasing: write 0x0000_1234 to 0x44A0_000C, read 0x0000_000C -> 0x0000_1234. Reading 0x44A0_0000 still returns 0x0000_0123.
- Errors: write 0xDEAD_BEEF to offset 0x040 (index 16) and to offset 0x002 -> o_pslverr=1 and o_prdata=0 in each access cycle. A full readback of indices 0..15 is unchanged.
- Back-to-back: write 0xA5A5_A5A5 to 0x3C, immediately followed by a read of 0x3C with no idle cycle -> 0xA5A5_A5A5. Fill all 16 registers with index*0x1111_1111, read all back and match.
- Reset mid-transfer: assert i_reset during the setup cycle of a write of 0xFFFF_FFFF to 0x04 -> no o_pready pulse; register 1 reads 0 after reset.

Source files
------------

// File: rtl/apb_reg_slave_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : apb_reg_slave_if
// Brief   : APB3 bus bundle between a master and the apb_reg_slave bank.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface apb_reg_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_psel;
  logic                  i_penable;
  logic                  i_pwrite;
  logic [ADDR_WIDTH-1:0] i_paddr;
  logic [DATA_WIDTH-1:0] i_pwdata;
  logic                  o_pready;
  logic [DATA_WIDTH-1:0] o_prdata;
  logic                  o_pslverr;

  modport master (
    output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
    input  o_pready, o_prdata, o_pslverr
  );

  modport slave (
    input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
    output o_pready, o_prdata, o_pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb_reg_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : apb_reg_slave
// Brief   : Zero-wait-state APB3 slave with a bank of read/write registers.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module apb_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  wire logic        i_clk,
  input  wire logic        i_reset,
  apb_reg_slave_if.slave   apb
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  pready_q,  pready_d;
  logic [DATA_WIDTH-1:0] prdata_q,  prdata_d;
  logic                  pslverr_q, pslverr_d;
  logic                  legal_q,   legal_d;
  logic [IDX_W-1:0]      idx_q,     idx_d;

  logic [11:0]           w_offset;
  logic [9:0]            w_index;
  logic                  w_legal;
  logic                  w_setup;
  logic                  w_commit;
  logic [IDX_W-1:0]      w_rd_idx;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_unused_bits;

  // Only the low 12 address bits decode, so the bank aliases at any base.
  assign w_offset      = apb.i_paddr[11:0];
  assign w_index       = w_offset[11:2];
  assign w_legal       = (w_offset[1:0] == 2'b00) && ({1'b0, w_index} < 11'(NUM_REGS));
  assign w_setup       = apb.i_psel & ~apb.i_penable;
  assign w_commit      = apb.i_psel & apb.i_penable & pready_q & apb.i_pwrite & legal_q;
  assign w_rd_idx      = w_legal ? w_index[IDX_W-1:0] : '0;
  assign w_rd_data     = regs_q[w_rd_idx];
  assign w_unused_bits = ^{apb.i_paddr, w_index};

  always_comb begin
    pready_d  = w_setup;
    prdata_d  = '0;
    pslverr_d = w_setup & ~w_legal;
    legal_d   = w_setup & w_legal;
    idx_d     = idx_q;
    if (w_setup) begin
      idx_d = w_rd_idx;
      if (w_legal && !apb.i_pwrite) begin
        prdata_d = w_rd_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      legal_q   <= 1'b0;
      idx_q     <= '0;
    end else begin
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      legal_q   <= legal_d;
      idx_q     <= idx_d;
    end
  end

  // The index latched in setup selects the target, so a write lands at the A-edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (w_commit) begin
      regs_q[idx_q] <= apb.i_pwdata;
    end
  end

  assign apb.o_pready  = pready_q;
  assign apb.o_prdata  = prdata_q;
  assign apb.o_pslverr = pslverr_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_apb_reg_slave
// Brief   : Directed self-checking bench for apb_reg_slave.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_apb_reg_slave;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  logic [31:0] exp_regs [16];

  apb_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .apb     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full two-cycle transfer starting just after a rising edge; leaves the bus idle
  // so a following call forms a back-to-back transfer.
  task automatic xfer(input string tag, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata);
    bit          legal;
    logic [31:0] exp_rd;
    legal  = (addr[1:0] == 2'b00) && (addr[11:2] < 10'd16);
    exp_rd = (legal && !wr) ? exp_regs[addr[5:2]] : 32'h0;
    bus.i_psel    = 1'b1;
    bus.i_penable = 1'b0;
    bus.i_pwrite  = wr;
    bus.i_paddr   = addr;
    bus.i_pwdata  = wdata;
    tick();
    check({tag, " pready"},  {31'h0, bus.o_pready},  32'h1);
    check({tag, " prdata"},  bus.o_prdata,           exp_rd);
    check({tag, " pslverr"}, {31'h0, bus.o_pslverr}, {31'h0, ~legal});
    bus.i_penable = 1'b1;
    tick();
    check({tag, " pready end"}, {31'h0, bus.o_pready}, 32'h0);
    check({tag, " prdata end"}, bus.o_prdata,          32'h0);
    if (wr && legal) exp_regs[addr[5:2]] = wdata;
    bus.i_psel    = 1'b0;
    bus.i_penable = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
    reset         = 1'b1;
    bus.i_psel    = 1'b0;
    bus.i_penable = 1'b0;
    bus.i_pwrite  = 1'b0;
    bus.i_paddr   = 32'h0;
    bus.i_pwdata  = 32'h0;
    tick();

    // Reset held with random bus activity
    for (int c = 0; c < 3; c++) begin
      bus.i_psel    = 1'($urandom);
      bus.i_penable = 1'($urandom);
      bus.i_pwrite  = 1'($urandom);
      bus.i_paddr   = $urandom & 32'hFFFF_F03C;
      bus.i_pwdata  = $urandom;
      tick();
    end
    check("rst pready",  {31'h0, bus.o_pready},  32'h0);
    check("rst prdata",  bus.o_prdata,           32'h0);
    check("rst pslverr", {31'h0, bus.o_pslverr}, 32'h0);
    reset         = 1'b0;
    bus.i_psel    = 1'b0;
    bus.i_penable = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) xfer($sformatf("rst rd%0d", i), 1'b0, 32'(i * 4), 32'h0);

    // Access phase without setup must not complete or write
    bus.i_psel    = 1'b1;
    bus.i_penable = 1'b1;
    bus.i_pwrite  = 1'b1;
    bus.i_paddr   = 32'h0000_0008;
    bus.i_pwdata  = 32'h0000_0055;
    tick();
    check("noset pready", {31'h0, bus.o_pready}, 32'h0);
    tick();
    check("noset pready2", {31'h0, bus.o_pready}, 32'h0);
    bus.i_psel    = 1'b0;
    bus.i_penable = 1'b0;
    tick();
    xfer("noset rd", 1'b0, 32'h0000_0008, 32'h0);

    // Write/read with aliasing
    xfer("wr0",   1'b1, 32'h44A0_0000, 32'h0000_0123);
    tick();
    xfer("rd0",   1'b0, 32'h44A0_0000, 32'h0);
    xfer("wrC",   1'b1, 32'h44A0_000C, 32'h0000_1234);
    xfer("rdC",   1'b0, 32'h0000_000C, 32'h0);
    xfer("rd0b",  1'b0, 32'h44A0_0000, 32'h0);
    check("model r3", exp_regs[3], 32'h0000_1234);

    // Error transfers
    xfer("err40",  1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
    xfer("err02",  1'b1, 32'h0000_0002, 32'hDEAD_BEEF);
    xfer("err40r", 1'b0, 32'h44A0_0040, 32'h0);
    xfer("errFFC", 1'b0, 32'h0000_0FFC, 32'h0);
    for (int i = 0; i < 16; i++) xfer($sformatf("chk rd%0d", i), 1'b0, 32'(i * 4), 32'h0);

    // Back-to-back write then read same index
    xfer("b2b wr", 1'b1, 32'h0000_003C, 32'hA5A5_A5A5);
    xfer("b2b rd", 1'b0, 32'h0000_003C, 32'h0);
    check("model r15", exp_regs[15], 32'hA5A5_A5A5);

    for (int i = 0; i < 16; i++) xfer($sformatf("fill%0d", i), 1'b1, 32'(i * 4), 32'(i) * 32'h1111_1111);
    for (int i = 0; i < 16; i++) xfer($sformatf("fillrd%0d", i), 1'b0, 32'(i * 4), 32'h0);

    // Reset during the setup cycle of a write
    bus.i_psel    = 1'b1;
    bus.i_penable = 1'b0;
    bus.i_pwrite  = 1'b1;
    bus.i_paddr   = 32'h0000_0004;
    bus.i_pwdata  = 32'hFFFF_FFFF;
    reset         = 1'b1;
    tick();
    check("midrst pready S", {31'h0, bus.o_pready}, 32'h0);
    reset         = 1'b0;
    bus.i_penable = 1'b1;
    tick();
    check("midrst pready A", {31'h0, bus.o_pready}, 32'h0);
    bus.i_psel    = 1'b0;
    bus.i_penable = 1'b0;
    for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
    tick();
    xfer("midrst rd1", 1'b0, 32'h0000_0004, 32'h0);
    xfer("midrst rd5", 1'b0, 32'h0000_0014, 32'h0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
